// File: rtl/apb_master.sv
// apb_master
// Single-outstanding APB4 requester. Accepts one command on a valid/ready
// stream, runs it as an APB SETUP/ACCESS transfer and returns one response
// on a valid/ready stream. It has a programmable wait-state timeout, so a
// stuck completer produces an error response instead of hanging the bus.
//
// Ports
//   clk, preset                  clock; synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write/addr/wdata/strb    command fields (strobes forced to 0 on reads)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/err/timeout        response fields, held stable while pending
//   psel/penable/pwrite/paddr/pwdata/pstrb   APB request signals
//   prdata/pready/pslverr        APB completer response
//
// State | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | response presented, waiting for rsp_ready
module apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        cmd_fire;
  logic        timeout_hit;

  assign cmd_fire = cmd_valid & cmd_ready;

  // The current cycle is the (wait_cnt+1)-th consecutive pready-low cycle;
  // abort on the edge that ends the TIMEOUT-th one.
  assign timeout_hit = (TIMEOUT != 0) && !pready &&
                       (({1'b0, wait_cnt} + 17'd1) >= TO_LIM);

  always_ff @(posedge clk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   psel      = 1'b1;
      ACCESS:  begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            pwrite   <= cmd_write;
            paddr    <= cmd_addr;
            pwdata   <= cmd_wdata;
            pstrb    <= cmd_write ? cmd_strb : '0;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master
// Directed bench for apb_master (TIMEOUT=8). The APB completer is driven
// directly by the stimulus steps; all expected values are hand-computed.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_apb_master;
  logic        clk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int total = 0;
  int bad   = 0;

  apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b1; prdata = '0;
    pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    preset = 1'b0;
    tick();

    // zero-wait write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h00C;
    cmd_wdata = 32'h0000_0003; cmd_strb = 4'h3; pready = 1'b1;
    prdata = 32'hFFFF_FFFF;
    tick();
    cmd_valid = 1'b0;
    chk("w_setup_psel", psel, 1);
    chk("w_setup_penable", penable, 0);
    chk("w_setup_cmd_ready", cmd_ready, 0);
    chk("w_paddr", paddr, 12'h00C);
    chk("w_pstrb", pstrb, 4'h3);
    chk("w_pwrite", pwrite, 1);
    chk("w_rsp_valid_early", rsp_valid, 0);
    tick();
    chk("w_access_psel", psel, 1);
    chk("w_access_penable", penable, 1);
    chk("w_rsp_valid_t1", rsp_valid, 0);
    tick();
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_resp_psel", psel, 0);
    chk("w_rsp_err", rsp_err, 0);
    chk("w_rsp_rdata", rsp_rdata, 0);
    chk("w_rsp_timeout", rsp_timeout, 0);
    tick();
    chk("w_idle_rsp_valid", rsp_valid, 0);
    chk("w_idle_cmd_ready", cmd_ready, 1);

    // read with 3 wait states; strobe input must be ignored
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h000; cmd_strb = 4'hF;
    pready = 1'b0; prdata = 32'h0000_00A5;
    tick();
    cmd_valid = 1'b0;
    chk("r_setup_pstrb", pstrb, 0);
    chk("r_pwrite", pwrite, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("r_wait_penable", penable, 1);
      chk("r_wait_pstrb", pstrb, 0);
      chk("r_wait_rsp_valid", rsp_valid, 0);
      tick();
    end
    pready = 1'b1;
    chk("r_last_penable", penable, 1);
    tick();
    pready = 1'b0;
    chk("r_rsp_valid", rsp_valid, 1);
    chk("r_rsp_rdata", rsp_rdata, 32'h0000_00A5);
    chk("r_rsp_err", rsp_err, 0);
    tick();

    // slave error on write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h004;
    cmd_wdata = 32'hCAFE_0001; cmd_strb = 4'hF; pready = 1'b1; pslverr = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    pslverr = 1'b0; pready = 1'b0;
    chk("e_rsp_valid", rsp_valid, 1);
    chk("e_rsp_err", rsp_err, 1);
    chk("e_rsp_timeout", rsp_timeout, 0);
    tick();

    // timeout after exactly 8 ACCESS cycles
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008;
    prdata = 32'hDEAD_BEEF; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t_access_psel", psel, 1);
      chk("t_access_penable", penable, 1);
      tick();
    end
    chk("t_psel_low", psel, 0);
    chk("t_rsp_valid", rsp_valid, 1);
    chk("t_rsp_err", rsp_err, 1);
    chk("t_rsp_timeout", rsp_timeout, 1);
    chk("t_rsp_rdata", rsp_rdata, 0);
    tick();

    // backpressure and back-to-back
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h010;
    cmd_wdata = 32'h1111_1111; cmd_strb = 4'hF; pready = 1'b1;
    prdata = 32'h5A5A_5A5A;
    tick();
    chk("b_a_paddr", paddr, 12'h010);
    chk("b_a_pwdata", pwdata, 32'h1111_1111);
    cmd_addr = 12'h020; cmd_wdata = 32'h2222_2222; cmd_strb = 4'h5;
    tick();
    chk("b_a_access_paddr", paddr, 12'h010);
    chk("b_a_access_pwdata", pwdata, 32'h1111_1111);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_rsp_valid", rsp_valid, 1);
      chk("b_hold_cmd_ready", cmd_ready, 0);
      chk("b_hold_rdata", rsp_rdata, 0);
      chk("b_hold_err", rsp_err, 0);
      chk("b_hold_psel", psel, 0);
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("b_idle_cmd_ready", cmd_ready, 1);
    chk("b_idle_psel", psel, 0);
    chk("b_idle_paddr_kept", paddr, 12'h010);
    tick();
    cmd_valid = 1'b0;
    chk("b_b_psel", psel, 1);
    chk("b_b_paddr", paddr, 12'h020);
    chk("b_b_pwdata", pwdata, 32'h2222_2222);
    chk("b_b_pstrb", pstrb, 4'h5);
    tick(); tick();
    chk("b_b_rsp_valid", rsp_valid, 1);
    tick();
    pready = 1'b0;

    // reset during ACCESS wait states
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("x_pre_penable", penable, 1);
    preset = 1'b1;
    tick();
    chk("x_psel", psel, 0);
    chk("x_penable", penable, 0);
    chk("x_rsp_valid", rsp_valid, 0);
    chk("x_paddr", paddr, 0);
    preset = 1'b0;
    pready = 1'b1;
    tick();
    chk("x_cmd_ready", cmd_ready, 1);
    tick();
    chk("x_no_rsp", rsp_valid, 0);
    chk("x_idle_psel", psel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
